// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared constants and period helper for the blink timebase
package blink_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd7;

  localparam int BTN_UP    = 0;
  localparam int BTN_DN    = 1;
  localparam int BTN_PAUSE = 2;

  // Each level halves the period.
  function automatic logic [31:0] period_for(input logic [31:0] base,
                                             input logic [LEVEL_W-1:0] eff);
    return base >> eff;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser, debounce and press strobe for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt_db;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt_db   <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= key_raw;
      sync2    <= sync1;
      stable_d <= stable;
      // Strobe only on press (stable falling), never on release.
      pulse    <= stable_d & ~stable;
      if (sync2 == stable) begin
        cnt_db <= '0;
      end else if (cnt_db == LAST) begin
        stable <= sync2;
        cnt_db <= '0;
      end else begin
        cnt_db <= cnt_db + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// rtl/blink_rate_ctrl.sv - button-driven speed/pause control and blink timebase
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int BASE_PERIOD     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [3:1]         KEY,
  input  logic               SW0,
  output logic               tick,
  output logic               phase_a,
  output logic               phase_b,
  output logic [LEVEL_W-1:0] level,
  output logic               paused,
  output logic [2:0]         btn_pulse
);

  // CLK_HZ documents the clock the base period was chosen for.
  localparam logic [31:0] BASE = (CLK_HZ > 0) ? 32'(BASE_PERIOD) : 32'(BASE_PERIOD);

  logic               sw_s1;
  logic               sw_s2;
  logic [LEVEL_W-1:0] eff;
  logic [31:0]        period;
  logic [31:0]        terminal;
  logic [31:0]        half_term;
  logic [31:0]        cnt;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .key_raw(KEY[i+1]),
      .pulse  (btn_pulse[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sw_s1 <= 1'b0;
      sw_s2 <= 1'b0;
    end else begin
      sw_s1 <= SW0;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      level  <= '0;
      paused <= 1'b0;
    end else begin
      // Simultaneous up and down presses cancel.
      if (btn_pulse[BTN_UP] && !btn_pulse[BTN_DN] && level != MAX_LEVEL) begin
        level <= level + 1'b1;
      end else if (btn_pulse[BTN_DN] && !btn_pulse[BTN_UP] && level != '0) begin
        level <= level - 1'b1;
      end
      if (btn_pulse[BTN_PAUSE]) begin
        paused <= ~paused;
      end
    end
  end

  always_comb begin
    eff       = sw_s2 ? MAX_LEVEL : level;
    period    = period_for(BASE, eff);
    terminal  = period - 32'd1;
    half_term = (period >> 1) - 32'd1;
  end

  // The >= compare wraps at once when a faster rate leaves cnt past the new end.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      cnt     <= '0;
      tick    <= 1'b0;
      phase_a <= 1'b0;
      phase_b <= 1'b0;
    end else if (paused) begin
      tick <= 1'b0;
    end else begin
      if (cnt >= terminal) begin
        cnt     <= '0;
        tick    <= 1'b1;
        phase_a <= ~phase_a;
      end else begin
        cnt  <= cnt + 32'd1;
        tick <= 1'b0;
      end
      if (cnt == half_term) begin
        phase_b <= ~phase_b;
      end
    end
  end

endmodule
